icache_tag_array: RTL and testbench
===================================

// Module: icache_tag_array
// PURPOSE
//   Set-associative tag/valid store for the instruction cache; successor to the single-way tagv store.
//   Holds WAYS ways. Looks up two consecutive sets per request (line-spanning fetch).
//   Compares tags in every way and returns per-line hit, one-hot hit way and a refill victim for line 0.
//   Adds a multi-cycle flush walker. Sits between the fetch stage (lookup) and the miss unit (refill).
// PARAMETERS
//   WAYS    4   ways per set; power of two, >=2; WAY_W = $clog2(WAYS)
//   SETS    64  sets; power of two; SET_W = $clog2(SETS)
//   TAG_W   20  tag bits stored per way (excluding the valid bit)
// PORTS
//   clk            in   1             clock
//   rst            in   1             synchronous reset, active-high
//   lookup_valid   in   1             lookup request
//   lookup_ready   out  1             request accepted when valid&ready
//   lookup_index   in   SET_W         set of line 0; line 1 uses (index+1) mod SETS
//   lookup_span    in   1             request spans into line 1
//   lookup_tag0    in   TAG_W         tag compared against line 0
//   lookup_tag1    in   TAG_W         tag compared against line 1
//   resp_valid     out  1             lookup result valid
//   resp_hit       out  2             [0] line 0 hit, [1] line 1 hit
//   resp_hit_way0  out  WAYS          one-hot hit way for line 0
//   resp_hit_way1  out  WAYS          one-hot hit way for line 1
//   resp_victim    out  WAY_W         refill victim way for the line-0 set
//   refill_valid   in   1             write tag+valid
//   refill_ready   out  1             refill accepted when valid&ready
//   refill_index   in   SET_W         set to write
//   refill_way     in   WAY_W         way to write
//   refill_tag     in   TAG_W         tag written; valid bit set to 1
//   flush_req      in   1             request invalidation of all entries
//   flush_busy     out  1             flush walker active
//   flush_done     out  1             one-cycle pulse when the flush completes
// BEHAVIOUR
//   Reset (rst high at clk edge):
//   - All valid bits cleared; all round-robin pointers cleared.
//   - FSM goes to IDLE.
//   - resp_valid, resp_hit, resp_hit_way0/1, resp_victim, flush_busy, flush_done all 0.
//   - Reset mid-flush aborts the flush with no flush_done pulse.
//   Lookup:
//   - lookup_ready = (state==IDLE).
//   - An accepted request produces resp_* on the next cycle, with resp_valid high for exactly that one cycle.
//   - Outputs are held between responses; resp_hit is 0 whenever resp_valid is 0.
//   - hit_wayN[w] = valid[set][w] && tag[set][w]==lookup_tagN.
//   - resp_hit[N] = |hit_wayN.
//   - lookup_span=0 forces resp_hit[1]=0 and resp_hit_way1=0.
//   - index=SETS-1 with span=1: line 1 wraps to set 0.
//   Victim selection (line-0 set, sampled with the lookup):
//   - Lowest-numbered invalid way, if any exists.
//   - Otherwise the set's round-robin pointer.
//   Refill:
//   - refill_ready = (state==IDLE).
//   - An accepted refill writes tag and valid=1 at the clock edge.
//   - The same refill advances that set's pointer by 1, mod WAYS.
//   Read/write collision: a lookup and a refill to the same set in the same cycle see the pre-write contents (read-before-write).
//   The write is visible to the next lookup.
//   Multiple hits in one set are illegal; they fire a simulation assertion. resp_hit_way then ORs all matches.
//   FSM IDLE -> FLUSH:
//   - Taken when flush_req=1 in IDLE. Flush has priority over a same-cycle lookup or refill; both ready signals are 0 in that cycle.
//   - The walk counter starts at 0.
//   FSM FLUSH -> FLUSH:
//   - Clears valid bits of all ways of set[cnt], then cnt++.
//   - flush_busy=1.
//   - Lookup and refill are stalled (ready=0).
//   - flush_req is ignored.
//   FSM FLUSH -> DONE: taken after set SETS-1 is cleared. Flush takes SETS cycles.
//   FSM DONE -> IDLE: flush_done=1 for this single cycle, flush_busy=0, ready=0; next cycle IDLE.
//   Round-robin pointers are not reset by flush.
//   A lookup response already in flight when flush starts is still delivered on the following cycle.
// TESTING
//   1. After reset, lookup index=5 tag0=0x12345 -> next cycle resp_valid=1, resp_hit=00, resp_victim=0.
//   2. Refill set 5 way 2 tag 0x12345, then lookup index 5 tag0 0x12345 -> resp_hit[0]=1, resp_hit_way0=4'b0100.
//   3. Refill set 0 way 1 tag 0xABC; lookup index=63 span=1 tag1=0xABC -> resp_hit=2'b10, resp_hit_way1=4'b0010.
//   4. Fill all 4 ways of set 7, then 2 more refills -> lookups report victim 0,1,2,3,0,1 after each step.
//   5. Same-cycle refill+lookup set 9 tag 0x55 -> miss; lookup on the next cycle -> hit.
//   6. flush_req with all sets valid -> busy 64 cycles, ready=0 throughout, flush_done pulse at cycle 65.
//      Every later lookup misses. Reset at cycle 30 of the flush -> no flush_done, state IDLE.

Source files
------------

// File: rtl/icache_tag_array.sv
// Set-associative tag/valid store for the instruction cache: dual-set lookup,
// round-robin refill victim selection and a multi-cycle flush walker.
module icache_tag_array #(
    parameter  int WAYS  = 4,
    parameter  int SETS  = 64,
    parameter  int TAG_W = 20,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lookup_valid_i,
    output logic             lookup_ready_o,
    input  logic [SET_W-1:0] lookup_index_i,
    input  logic             lookup_span_i,
    input  logic [TAG_W-1:0] lookup_tag0_i,
    input  logic [TAG_W-1:0] lookup_tag1_i,
    output logic             resp_valid_o,
    output logic [1:0]       resp_hit_o,
    output logic [WAYS-1:0]  resp_hit_way0_o,
    output logic [WAYS-1:0]  resp_hit_way1_o,
    output logic [WAY_W-1:0] resp_victim_o,
    input  logic             refill_valid_i,
    output logic             refill_ready_o,
    input  logic [SET_W-1:0] refill_index_i,
    input  logic [WAY_W-1:0] refill_way_i,
    input  logic [TAG_W-1:0] refill_tag_i,
    input  logic             flush_req_i,
    output logic             flush_busy_o,
    output logic             flush_done_o
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DONE
    } state_e;

    state_e           state_q;
    logic [SET_W-1:0] cnt_q;
    logic [WAYS-1:0]  valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [WAY_W-1:0] rr_q    [SETS];

    logic             resp_valid_q;
    logic [1:0]       resp_hit_q;
    logic [WAYS-1:0]  resp_hit_way0_q;
    logic [WAYS-1:0]  resp_hit_way1_q;
    logic [WAY_W-1:0] resp_victim_q;
    logic             flush_busy_q;
    logic             flush_done_q;

    logic             idle;
    logic             lookup_fire;
    logic             refill_fire;
    logic [SET_W-1:0] index1;
    logic [WAYS-1:0]  hit_way0_d;
    logic [WAYS-1:0]  hit_way1_d;
    logic [WAY_W-1:0] victim_d;
    logic             victim_found;

    // A pending flush request steals the cycle from lookup and refill.
    assign idle           = (state_q == IDLE);
    assign lookup_ready_o = idle && !flush_req_i;
    assign refill_ready_o = idle && !flush_req_i;
    assign lookup_fire    = lookup_valid_i && lookup_ready_o;
    assign refill_fire    = refill_valid_i && refill_ready_o;
    assign index1         = lookup_index_i + 1'b1;

    always_comb begin
        hit_way0_d   = '0;
        hit_way1_d   = '0;
        victim_d     = rr_q[lookup_index_i];
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_way0_d[w] = valid_q[lookup_index_i][w] &&
                            (tag_q[lookup_index_i][w] == lookup_tag0_i);
            hit_way1_d[w] = lookup_span_i && valid_q[index1][w] &&
                            (tag_q[index1][w] == lookup_tag1_i);
            if (!victim_found && !valid_q[lookup_index_i][w]) begin
                victim_d     = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    // Tag storage carries no reset; only the valid bits qualify its contents.
    always_ff @(posedge clk_i) begin
        if (refill_fire) begin
            tag_q[refill_index_i][refill_way_i] <= refill_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= '0;
            resp_hit_way0_q <= '0;
            resp_hit_way1_q <= '0;
            resp_victim_q   <= '0;
            flush_busy_q    <= 1'b0;
            flush_done_q    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_req_i) begin
                        state_q      <= FLUSH;
                        cnt_q        <= '0;
                        flush_busy_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    valid_q[cnt_q] <= '0;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == SET_W'(SETS - 1)) begin
                        state_q      <= DONE;
                        flush_busy_q <= 1'b0;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (refill_fire) begin
                valid_q[refill_index_i][refill_way_i] <= 1'b1;
                rr_q[refill_index_i] <= rr_q[refill_index_i] + 1'b1;
            end

            // Lookup reads the pre-write arrays, so a same-cycle refill is invisible.
            resp_valid_q <= lookup_fire;
            if (lookup_fire) begin
                resp_hit_q      <= {|hit_way1_d, |hit_way0_d};
                resp_hit_way0_q <= hit_way0_d;
                resp_hit_way1_q <= hit_way1_d;
                resp_victim_q   <= victim_d;
            end else begin
                resp_hit_q <= '0;
            end
        end
    end

    // Duplicate tags within one set indicate a miss-unit bug upstream.
    always_ff @(posedge clk_i) begin
        if (!rst_i && lookup_fire) begin
            assert ($onehot0(hit_way0_d) && $onehot0(hit_way1_d))
            else $error("icache_tag_array: multiple ways hit in one set");
        end
    end

    assign resp_valid_o    = resp_valid_q;
    assign resp_hit_o      = resp_hit_q;
    assign resp_hit_way0_o = resp_hit_way0_q;
    assign resp_hit_way1_o = resp_hit_way1_q;
    assign resp_victim_o   = resp_victim_q;
    assign flush_busy_o    = flush_busy_q;
    assign flush_done_o    = flush_done_q;

endmodule

// File: tb/tb_icache_tag_array.sv
// Directed plus randomized bench for icache_tag_array, checked against a
// set/way array model of the tag store kept in the bench.
module tb_icache_tag_array;

    localparam int WAYS  = 4;
    localparam int SETS  = 64;
    localparam int TAG_W = 20;
    localparam int WAY_W = 2;
    localparam int SET_W = 6;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             lookup_valid_i;
    logic             lookup_ready_o;
    logic [SET_W-1:0] lookup_index_i;
    logic             lookup_span_i;
    logic [TAG_W-1:0] lookup_tag0_i;
    logic [TAG_W-1:0] lookup_tag1_i;
    logic             resp_valid_o;
    logic [1:0]       resp_hit_o;
    logic [WAYS-1:0]  resp_hit_way0_o;
    logic [WAYS-1:0]  resp_hit_way1_o;
    logic [WAY_W-1:0] resp_victim_o;
    logic             refill_valid_i;
    logic             refill_ready_o;
    logic [SET_W-1:0] refill_index_i;
    logic [WAY_W-1:0] refill_way_i;
    logic [TAG_W-1:0] refill_tag_i;
    logic             flush_req_i;
    logic             flush_busy_o;
    logic             flush_done_o;

    int checks = 0;
    int errors = 0;

    bit mValid [SETS][WAYS];
    int mTag   [SETS][WAYS];
    int mRr    [SETS];

    always #5 clk_i = ~clk_i;

    icache_tag_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lookup_valid_i  (lookup_valid_i),
        .lookup_ready_o  (lookup_ready_o),
        .lookup_index_i  (lookup_index_i),
        .lookup_span_i   (lookup_span_i),
        .lookup_tag0_i   (lookup_tag0_i),
        .lookup_tag1_i   (lookup_tag1_i),
        .resp_valid_o    (resp_valid_o),
        .resp_hit_o      (resp_hit_o),
        .resp_hit_way0_o (resp_hit_way0_o),
        .resp_hit_way1_o (resp_hit_way1_o),
        .resp_victim_o   (resp_victim_o),
        .refill_valid_i  (refill_valid_i),
        .refill_ready_o  (refill_ready_o),
        .refill_index_i  (refill_index_i),
        .refill_way_i    (refill_way_i),
        .refill_tag_i    (refill_tag_i),
        .flush_req_i     (flush_req_i),
        .flush_busy_o    (flush_busy_o),
        .flush_done_o    (flush_done_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    function automatic int modelHitMask(input int set, input int tag);
        int mask = 0;
        for (int w = 0; w < WAYS; w++)
            if (mValid[set][w] && mTag[set][w] == tag) mask |= (1 << w);
        return mask;
    endfunction

    function automatic int modelVictim(input int set);
        for (int w = 0; w < WAYS; w++)
            if (!mValid[set][w]) return w;
        return mRr[set];
    endfunction

    function automatic void modelClearValid();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mValid[s][w] = 1'b0;
    endfunction

    task automatic resetDut();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        modelClearValid();
        for (int s = 0; s < SETS; s++) mRr[s] = 0;
    endtask

    // One IDLE-state cycle: optional lookup and/or refill, response checked afterwards.
    task automatic applyStimulus(input bit lv, input int idx, input bit span, input int t0, input int t1,
                                 input bit rv, input int ridx, input int rway, input int rtag);
        int eHit0, eHit1, eVic;
        logic [1:0] eHit;
        lookup_valid_i = lv;
        lookup_index_i = SET_W'(idx);
        lookup_span_i  = span;
        lookup_tag0_i  = TAG_W'(t0);
        lookup_tag1_i  = TAG_W'(t1);
        refill_valid_i = rv;
        refill_index_i = SET_W'(ridx);
        refill_way_i   = WAY_W'(rway);
        refill_tag_i   = TAG_W'(rtag);
        #1;
        checkOutput("lookup_ready", lookup_ready_o, 1);
        checkOutput("refill_ready", refill_ready_o, 1);
        eHit0 = modelHitMask(idx, t0);
        eHit1 = span ? modelHitMask((idx + 1) % SETS, t1) : 0;
        eVic  = modelVictim(idx);
        @(posedge clk_i);
        if (rv) begin
            mValid[ridx][rway] = 1'b1;
            mTag[ridx][rway]   = rtag;
            mRr[ridx]          = (mRr[ridx] + 1) % WAYS;
        end
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
        refill_valid_i = 1'b0;
        eHit = {eHit1 != 0, eHit0 != 0};
        checkOutput("resp_valid", resp_valid_o, lv);
        if (lv) begin
            checkOutput("resp_hit", resp_hit_o, eHit);
            checkOutput("resp_hit_way0", resp_hit_way0_o, eHit0);
            checkOutput("resp_hit_way1", resp_hit_way1_o, eHit1);
            checkOutput("resp_victim", resp_victim_o, eVic);
        end else begin
            checkOutput("resp_hit_idle", resp_hit_o, 0);
        end
    endtask

    task automatic startFlush();
        flush_req_i    = 1'b1;
        lookup_valid_i = 1'b1;
        refill_valid_i = 1'b1;
        refill_index_i = '0;
        refill_tag_i   = TAG_W'(32'h777);
        #1;
        checkOutput("flush_lookup_ready", lookup_ready_o, 0);
        checkOutput("flush_refill_ready", refill_ready_o, 0);
        @(negedge clk_i);
        flush_req_i    = 1'b0;
        lookup_valid_i = 1'b0;
        refill_valid_i = 1'b0;
        checkOutput("flush_no_resp", resp_valid_o, 0);
    endtask

    initial begin
        int idx, t0, t1, ridx, rway, rtag, vic;
        bit lv, rv, span, sawDone;

        rst_i = 1'b1;
        lookup_valid_i = 1'b0; lookup_index_i = '0; lookup_span_i = 1'b0;
        lookup_tag0_i = '0; lookup_tag1_i = '0;
        refill_valid_i = 1'b0; refill_index_i = '0; refill_way_i = '0; refill_tag_i = '0;
        flush_req_i = 1'b0;
        @(negedge clk_i);
        resetDut();

        checkOutput("reset_resp_valid", resp_valid_o, 0);
        checkOutput("reset_resp_hit", resp_hit_o, 0);
        checkOutput("reset_hit_way0", resp_hit_way0_o, 0);
        checkOutput("reset_hit_way1", resp_hit_way1_o, 0);
        checkOutput("reset_victim", resp_victim_o, 0);
        checkOutput("reset_flush_busy", flush_busy_o, 0);
        checkOutput("reset_flush_done", flush_done_o, 0);

        applyStimulus(1, 5, 0, 'h12345, 0, 0, 0, 0, 0);
        checkOutput("t1_hit", resp_hit_o, 2'b00);

        applyStimulus(0, 0, 0, 0, 0, 1, 5, 2, 'h12345);
        applyStimulus(1, 5, 0, 'h12345, 0, 0, 0, 0, 0);
        checkOutput("t2_way0", resp_hit_way0_o, 4'b0100);

        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 'hABC);
        applyStimulus(1, 63, 1, 'h1, 'hABC, 0, 0, 0, 0);
        checkOutput("t3_hit_wrap", resp_hit_o, 2'b10);
        checkOutput("t3_way1_wrap", resp_hit_way1_o, 4'b0010);
        applyStimulus(1, 63, 0, 'h1, 'hABC, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 7, 0, 'hFFFFF, 0, 0, 0, 0, 0);
            vic = modelVictim(7);
            applyStimulus(0, 0, 0, 0, 0, 1, 7, vic, 'h700 + i);
        end
        applyStimulus(1, 7, 0, 'hFFFFF, 0, 0, 0, 0, 0);

        applyStimulus(1, 9, 0, 'h55, 0, 1, 9, 0, 'h55);
        checkOutput("t5_collision_miss", resp_hit_o, 2'b00);
        applyStimulus(1, 9, 0, 'h55, 0, 0, 0, 0, 0);
        checkOutput("t5_next_hit", resp_hit_o, 2'b01);

        for (int i = 0; i < 300; i++) begin
            idx  = ($urandom_range(0, 4) == 4) ? 63 : $urandom_range(0, 3);
            ridx = ($urandom_range(0, 4) == 4) ? 63 : $urandom_range(0, 3);
            lv   = $urandom_range(0, 1);
            rv   = $urandom_range(0, 1);
            span = $urandom_range(0, 1);
            t0   = $urandom_range(0, 7);
            t1   = $urandom_range(0, 7);
            rtag = $urandom_range(0, 7);
            rway = $urandom_range(0, WAYS - 1);
            for (int w = 0; w < WAYS; w++)
                if (mValid[ridx][w] && mTag[ridx][w] == rtag) rway = w;
            applyStimulus(lv, idx, span, t0, t1, rv, ridx, rway, rtag);
        end

        for (int s = 0; s < SETS; s++)
            applyStimulus(0, 0, 0, 0, 0, 1, s, 0, 'h100 + s);
        applyStimulus(1, 20, 1, 'h114, 'h115, 0, 0, 0, 0);
        checkOutput("preflush_hit", resp_hit_o, 2'b11);

        startFlush();
        for (int i = 0; i < SETS; i++) begin
            checkOutput("flush_busy", flush_busy_o, 1);
            checkOutput("flush_done_early", flush_done_o, 0);
            checkOutput("flush_stall_ready", lookup_ready_o, 0);
            flush_req_i = (i == 10);
            @(negedge clk_i);
        end
        flush_req_i = 1'b0;
        checkOutput("done_pulse", flush_done_o, 1);
        checkOutput("done_busy", flush_busy_o, 0);
        checkOutput("done_ready", lookup_ready_o, 0);
        @(negedge clk_i);
        checkOutput("done_cleared", flush_done_o, 0);
        checkOutput("post_flush_busy", flush_busy_o, 0);
        modelClearValid();
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(0, SETS - 1);
            applyStimulus(1, idx, 1, 'h100 + idx, 'h100 + (idx + 1) % SETS, 0, 0, 0, 0);
            checkOutput("post_flush_miss", resp_hit_o, 2'b00);
        end

        applyStimulus(0, 0, 0, 0, 0, 1, 3, 1, 'h33);
        startFlush();
        repeat (29) @(negedge clk_i);
        checkOutput("mid_flush_busy", flush_busy_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        modelClearValid();
        for (int s = 0; s < SETS; s++) mRr[s] = 0;
        checkOutput("abort_busy", flush_busy_o, 0);
        checkOutput("abort_done", flush_done_o, 0);
        checkOutput("abort_ready", lookup_ready_o, 1);
        sawDone = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (flush_done_o !== 1'b0) sawDone = 1'b1;
            @(negedge clk_i);
        end
        checkOutput("abort_no_done", sawDone, 0);
        applyStimulus(1, 3, 0, 'h33, 0, 0, 0, 0, 0);
        checkOutput("abort_victim", resp_victim_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
